xup_xnor_share_ctrl: RTL and testbench

- Round-robin controller that time-shares one xnor vector datapath among NREQ requesters.
- Each requester presents an operand pair. The controller grants one requester, latches its operands and drives them into the shared xnor instance.
- It waits a programmable settle time for the gate delays, then captures the result and returns it with a per-requester done pulse and an all-ones match flag (bitwise equality compare).
- Used as the shared equality/compare resource in XUP lab designs.

---
 rtl/xup_xnor_share_ctrl_pkg.sv | 5 +
 rtl/xup_xnor_vector.sv | 14 +
 rtl/xup_xnor_share_ctrl.sv | 99 +++++++++
 tb/tb_xup_xnor_share_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/xup_xnor_share_ctrl_pkg.sv
// xup_xnor_share_ctrl_pkg: shared state encoding and counter width for the xnor share controller.
package xup_xnor_share_ctrl_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;
    localparam int CNT_W = 4;
endpackage

// File: rtl/xup_xnor_vector.sv
// xup_xnor_vector: bitwise xnor of two vectors; DELAY is the nominal gate delay the controller settles for.
module xup_xnor_vector #(
    parameter int SIZE  = 8,
    parameter int DELAY = 3
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic [SIZE-1:0] y
);
    if (DELAY < 0) begin : g_bad_delay
        $error("xup_xnor_vector: DELAY must be non-negative");
    end
    assign y = a ~^ b;
endmodule

// File: rtl/xup_xnor_share_ctrl.sv
// xup_xnor_share_ctrl: round-robin time-sharing of one xnor vector among NREQ requesters,
// with programmable settle time, per-requester done pulse and all-ones match flag.
module xup_xnor_share_ctrl
    import xup_xnor_share_ctrl_pkg::*;
#(
    parameter int SIZE   = 8,
    parameter int NREQ   = 4,
    parameter int SETTLE = 2,
    parameter int DELAY  = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*SIZE-1:0] a_in,
    input  logic [NREQ*SIZE-1:0] b_in,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [SIZE-1:0]      result,
    output logic                 match,
    output logic                 busy
);
    localparam int IW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("xup_xnor_share_ctrl: NREQ must be 2..8");
    end
    if (SETTLE < 0 || SETTLE > 15) begin : g_bad_settle
        $error("xup_xnor_share_ctrl: SETTLE must be 0..15");
    end

    state_t          state;
    logic [SIZE-1:0] a_reg;
    logic [SIZE-1:0] b_reg;
    logic [SIZE-1:0] y;
    logic [CNT_W-1:0] cnt;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   last;
    logic [IW-1:0]   win;

    // Rotate so last+1 sits at bit 0, take the lowest set bit, then rotate the index back.
    function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] l);
        logic [2*NREQ-1:0] dbl;
        logic [NREQ-1:0]   rot;
        int s;
        int p;
        s   = (int'(l) + 1) % NREQ;
        dbl = {r, r} >> s;
        rot = dbl[NREQ-1:0];
        p   = 0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (rot[i]) p = i;
        return IW'((s + p) % NREQ);
    endfunction

    assign win  = rr_pick(req, last);
    assign busy = state == ST_RUN;

    xup_xnor_vector #(.SIZE(SIZE), .DELAY(DELAY)) u_xnor (
        .a(a_reg),
        .b(b_reg),
        .y(y)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            cnt    <= '0;
            owner  <= '0;
            last   <= IW'(NREQ - 1);
            gnt    <= '0;
            done   <= '0;
            result <= '0;
            match  <= 1'b0;
        end else begin
            gnt  <= '0;
            done <= '0;
            if (state == ST_IDLE) begin
                if (|req) begin
                    a_reg <= a_in[win*SIZE +: SIZE];
                    b_reg <= b_in[win*SIZE +: SIZE];
                    gnt   <= NREQ'(1) << win;
                    owner <= win;
                    last  <= win;
                    cnt   <= CNT_W'(SETTLE);
                    state <= ST_RUN;
                end
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else begin
                result <= y;
                match  <= &y;
                done   <= NREQ'(1) << owner;
                state  <= ST_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_xup_xnor_share_ctrl.sv
// tb_xup_xnor_share_ctrl: directed vector table plus hand sequences for fairness,
// RUN-time requests and reset mid-operation.
module tb_xup_xnor_share_ctrl;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [7:0]  result;
    logic        match;
    logic        busy;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic [3:0] req;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] gnt;
        logic [7:0] res;
        logic       m;
    } vec_t;

    vec_t tbl[8];

    xup_xnor_share_ctrl #(.SIZE(8), .NREQ(4), .SETTLE(2), .DELAY(3)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req(req),
        .a_in(a_in),
        .b_in(b_in),
        .gnt(gnt),
        .done(done),
        .result(result),
        .match(match),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (done == 4'b0 && n < 20);
    endtask

    int n;
    int ng;
    int gi;
    int gc;
    int extra;

    initial begin
        tbl[0] = '{4'b0100, 8'hA5, 8'hA5, 4'b0100, 8'hFF, 1'b1};
        tbl[1] = '{4'b0001, 8'hF0, 8'h0F, 4'b0001, 8'h00, 1'b0};
        tbl[2] = '{4'b0001, 8'h3C, 8'h35, 4'b0001, 8'hF6, 1'b0};
        tbl[3] = '{4'b0010, 8'h12, 8'h12, 4'b0010, 8'hFF, 1'b1};
        tbl[4] = '{4'b1001, 8'h00, 8'hFF, 4'b1000, 8'h00, 1'b0};
        tbl[5] = '{4'b1001, 8'h5A, 8'h5B, 4'b0001, 8'hFE, 1'b0};
        tbl[6] = '{4'b1111, 8'hC3, 8'hC3, 4'b0010, 8'hFF, 1'b1};
        tbl[7] = '{4'b1100, 8'h81, 8'h7E, 4'b0100, 8'h00, 1'b0};

        reset_n = 1'b0;
        req     = 4'b0;
        a_in    = '0;
        b_in    = '0;
        #12;
        check("reset outputs", {gnt, done, result, match, busy}, 0);
        reset_n = 1'b1;
        tick();
        tick();
        check("idle without req", {gnt, busy}, 0);

        for (int i = 0; i < 8; i++) begin
            req  = tbl[i].req;
            a_in = {4{tbl[i].a}};
            b_in = {4{tbl[i].b}};
            tick();
            check($sformatf("v%0d gnt", i), gnt, tbl[i].gnt);
            check($sformatf("v%0d busy", i), busy, 1);
            req = 4'b0;
            wait_done(n);
            check($sformatf("v%0d latency", i), n, 3);
            check($sformatf("v%0d done", i), done, tbl[i].gnt);
            check($sformatf("v%0d result", i), result, tbl[i].res);
            check($sformatf("v%0d match", i), match, tbl[i].m);
            check($sformatf("v%0d busy end", i), busy, 0);
        end

        // Fairness: all four requesting from reset, each with distinct operands.
        reset_n = 1'b0;
        req     = 4'b1111;
        for (int k = 0; k < 4; k++) a_in[k*8 +: 8] = 8'hA0 | 8'(k);
        b_in = {4{8'hA0}};
        tick();
        reset_n = 1'b1;
        ng = 0;
        gi = 0;
        gc = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            check("gnt onehot", $countones(gnt) <= 1, 1);
            check("done onehot", $countones(done) <= 1, 1);
            if (gnt != 4'b0) begin
                check($sformatf("fair gnt %0d", ng), gnt, 4'b0001 << (ng % 4));
                if (ng > 0) check($sformatf("fair spacing %0d", ng), c - gc, 4);
                gi = ng % 4;
                gc = c;
                ng++;
            end
            if (done != 4'b0) begin
                check("fair done target", done, 4'b0001 << gi);
                check("fair result", result, 8'hFF ^ 8'(gi));
            end
        end
        check("fair grant count", ng, 5);
        req = 4'b0;

        // Request raised during RUN and dropped before the IDLE edge is never granted.
        a_in = {4{8'h11}};
        b_in = {4{8'h22}};
        req  = 4'b0001;
        tick();
        check("run5a gnt", gnt, 4'b0001);
        req = 4'b0;
        tick();
        req = 4'b0100;
        wait_done(n);
        check("run5a latency", n, 2);
        check("run5a done", done, 4'b0001);
        req = 4'b0;
        extra = 0;
        repeat (6) begin
            tick();
            if (gnt != 4'b0) extra++;
        end
        check("run5a no grant", extra, 0);

        // Request held through the IDLE edge is granted right after done.
        req = 4'b0001;
        tick();
        req = 4'b0;
        tick();
        req = 4'b0100;
        wait_done(n);
        check("run5b done", done, 4'b0001);
        check("run5b no overlap", gnt, 4'b0);
        tick();
        check("run5b gnt", gnt, 4'b0100);
        check("run5b done cleared", done, 4'b0);
        req = 4'b0;
        wait_done(n);
        check("run5b done2", done, 4'b0100);
        check("run5b result", result, 8'hCC);

        // Reset mid-RUN with cnt=1: everything clears, no done, pointer restarts at 0.
        req = 4'b0001;
        tick();
        check("rst6 gnt", gnt, 4'b0001);
        req = 4'b0;
        tick();
        reset_n = 1'b0;
        #1;
        check("rst6 outputs", {gnt, done, result, match, busy}, 0);
        tick();
        reset_n = 1'b1;
        extra = 0;
        repeat (4) begin
            tick();
            if (done != 4'b0 || busy) extra++;
        end
        check("rst6 no done", extra, 0);
        req = 4'b1001;
        tick();
        check("rst6 regrant", gnt, 4'b0001);
        req = 4'b0;
        wait_done(n);
        check("rst6 latency", n, 3);
        check("rst6 done", done, 4'b0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
